// File: rtl/instr_mem.sv
// Instruction memory: registered single-cycle fetch, preloadable storage.
// Optional write port enabled by defining INSTR_MEM_WRITE_EN.
module instr_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] pc,
`ifdef INSTR_MEM_WRITE_EN
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
`endif
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // No reset and no initial value: contents come from preload or writes.
  logic [DATA_WIDTH-1:0] instrmem [0:DEPTH-1];

  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;

  // Next fetch word/valid; the old word is held when no fetch occurs.
  always_comb begin
    instr_d = instr_q;
    valid_d = 1'b0;
    if (enable) begin
      instr_d = instrmem[pc];
      valid_d = 1'b1;
    end
  end

  // Output registers; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

`ifdef INSTR_MEM_WRITE_EN
  // Write port; the fetch above samples the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      instrmem[wr_addr] <= wr_data;
    end
  end
`endif

  assign instruction = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_mem.sv
// Scoreboard bench for instr_mem: driver pushes expected fetch results,
// monitor pops and compares one cycle later. Honors INSTR_MEM_WRITE_EN.
module tb_instr_mem;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] instruction;
  logic          instr_valid;

  int errors = 0;
  int checks = 0;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic [DW-1:0] model_out = '0;

  instr_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pc         (pc),
`ifdef INSTR_MEM_WRITE_EN
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`endif
    .instruction(instruction),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e,
                      input logic [AW-1:0] p,
                      input logic we = 1'b0,
                      input logic [AW-1:0] wa = '0,
                      input logic [DW-1:0] wd = '0);
    exp_t x;
    @(negedge clk);
    reset   = r;
    enable  = e;
    pc      = p;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    if (r) begin
      model_out = '0;
      x.v = 1'b0;
    end else if (e) begin
      model_out = model_mem[p];
      x.v = 1'b1;
    end else begin
      x.v = 1'b0;
    end
    x.d = model_out;
    sb.push_back(x);
`ifdef INSTR_MEM_WRITE_EN
    if (!r && we) model_mem[wa] = wd;
`endif
  endtask

  // Monitor: compare at edge+1, then confirm output stable mid-cycle.
  initial begin
    exp_t x;
    logic [DW-1:0] held;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (instruction !== x.d) begin
          errors++;
          $display("FAIL instr: got %h want %h at %0t",
                   instruction, x.d, $time);
        end
        checks++;
        if (instr_valid !== x.v) begin
          errors++;
          $display("FAIL valid: got %b want %b at %0t",
                   instr_valid, x.v, $time);
        end
        held = instruction;
        @(negedge clk);
        #1;
        checks++;
        if (instruction !== held) begin
          errors++;
          $display("FAIL stable: got %h want %h at %0t",
                   instruction, held, $time);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = DW'($urandom);
      model_mem[i] = w;
      dut.instrmem[i] = w;
    end
    model_mem[0] = 16'h1234;  dut.instrmem[0] = 16'h1234;
    model_mem[1] = 16'hABCD;  dut.instrmem[1] = 16'hABCD;
    model_mem[63] = 16'hFFFF; dut.instrmem[63] = 16'hFFFF;

    step(1'b1, 1'b0, 6'd0);
    step(1'b0, 1'b1, 6'd0);
    step(1'b0, 1'b1, 6'd1);
    step(1'b0, 1'b1, 6'd2);
    step(1'b0, 1'b1, 6'd3);
    step(1'b0, 1'b1, 6'd1);
    step(1'b0, 1'b0, 6'd0);
    step(1'b0, 1'b0, 6'd5);
    step(1'b1, 1'b1, 6'd1);
    step(1'b0, 1'b1, 6'd1);
    step(1'b0, 1'b1, 6'd63);
    step(1'b0, 1'b0, 6'd63);
`ifdef INSTR_MEM_WRITE_EN
    step(1'b0, 1'b1, 6'd5, 1'b1, 6'd5, 16'h5A5A);
    step(1'b0, 1'b1, 6'd5);
    step(1'b1, 1'b1, 6'd7, 1'b1, 6'd7, 16'hDEAD);
    step(1'b0, 1'b1, 6'd7);
`endif

    for (int n = 0; n < 400; n++) begin
      logic          r, e, we;
      logic [AW-1:0] p, wa;
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      p  = AW'($urandom);
      we = ($urandom_range(0, 2) == 0);
      wa = ($urandom_range(0, 3) == 0) ? p : AW'($urandom);
      step(r, e, p, we, wa, DW'($urandom));
    end

    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    wr_en  = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
